// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request per fetch start, latches the
// returned word into the instruction register and owns the program counter.
module fetch_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_fetch_pulse,
  input  logic       en_pc_pulse,
  input  logic [1:0] pc_ctrl,
  input  logic [7:0] pc_target,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_rdata,
  output logic       en1,
  output logic [3:0] opcode,
  output logic [1:0] rd,
  output logic [1:0] rs,
  output logic [7:0] pc,
  output logic       fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_r, state_s;
  logic       start_s;
  logic       timeout_s;
  logic       ack_s;
  logic [7:0] pc_r, pc_s;
  logic [7:0] addr_r;
  logic [7:0] ir_r;
  logic [7:0] tcnt_r;
  logic       req_r;
  logic       en1_r;
  logic       err_r;

  // Next-state decode; a fetch may start from IDLE or ERR only
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    ack_s     = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE, ERR: begin
        if (en_fetch_pulse) begin
          state_s = REQ;
          start_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      REQ: begin
        if (imem_ack) begin
          state_s = DONE;
          ack_s   = 1'b1;
        end else if (tcnt_r == TO_LAST) begin
          state_s   = ERR;
          timeout_s = 1'b1;
        end else begin
          state_s = REQ;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // PC update mode decode
  always_comb begin
    pc_s = pc_r;
    if (en_pc_pulse) begin
      case (pc_ctrl)
        2'b00:   pc_s = pc_r;
        2'b01:   pc_s = pc_r + 8'd1;
        2'b10:   pc_s = pc_target;
        2'b11:   pc_s = 8'd0;
        default: pc_s = pc_r;
      endcase
    end else begin
      pc_s = pc_r;
    end
  end

  // State, datapath and registered outputs (outputs follow the next state)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      pc_r    <= 8'd0;
      addr_r  <= 8'd0;
      ir_r    <= 8'd0;
      tcnt_r  <= 8'd0;
      req_r   <= 1'b0;
      en1_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      req_r   <= (state_s == REQ);
      en1_r   <= (state_s == DONE);
      // address captures the pre-update PC even when a PC strobe coincides
      if (start_s) begin
        addr_r <= pc_r;
        tcnt_r <= 8'd0;
      end else if (state_r == REQ && !imem_ack) begin
        tcnt_r <= tcnt_r + 8'd1;
      end else begin
        tcnt_r <= tcnt_r;
      end
      if (ack_s) begin
        ir_r <= imem_rdata;
      end else begin
        ir_r <= ir_r;
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end else if (start_s) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign imem_req  = req_r;
  assign imem_addr = addr_r;
  assign en1       = en1_r;
  assign opcode    = ir_r[7:4];
  assign rd        = ir_r[3:2];
  assign rs        = ir_r[1:0];
  assign pc        = pc_r;
  assign fetch_err = err_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetches
// compared against a cycle-count reference model of the fetch protocol.
module tb_fetch_unit;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_fetch_pulse;
  logic       en_pc_pulse;
  logic [1:0] pc_ctrl;
  logic [7:0] pc_target;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic       en1;
  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] pc;
  logic       fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_pc;
  logic [7:0] m_ir;

  logic [1:0] pcu_ctrl [5] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b00};
  logic [7:0] pcu_tgt  [5] = '{8'hFF, 8'h00, 8'h42, 8'h00, 8'h00};
  logic [7:0] pcu_exp  [5] = '{8'hFF, 8'h00, 8'h42, 8'h00, 8'h00};

  fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_fetch_pulse (en_fetch_pulse),
    .en_pc_pulse    (en_pc_pulse),
    .pc_ctrl        (pc_ctrl),
    .pc_target      (pc_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .en1            (en1),
    .opcode         (opcode),
    .rd             (rd),
    .rs             (rs),
    .pc             (pc),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pc_rule(input logic [7:0] p, input logic [1:0] c, input logic [7:0] t);
    int v;
    case (c)
      2'd0: v = int'(p);
      2'd1: v = (int'(p) + 1) % 256;
      2'd2: v = int'(t);
      default: v = 0;
    endcase
    return 8'(v);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One fetch from IDLE or ERR; delay = REQ cycles without ack before the ack cycle
  task automatic do_fetch(input logic pc_now, input logic [1:0] ctrl, input logic [7:0] tgt,
                          input int delay, input logic [7:0] rdata, input logic spam,
                          input logic mid_pc, input string tag);
    logic ok;
    int last;
    logic [7:0] addr_exp;
    logic exp_req, exp_en1, exp_err;
    ok = (delay < TIMEOUT);
    last = ok ? delay + 2 : TIMEOUT + 1;
    addr_exp = m_pc;
    en_fetch_pulse = 1'b1;
    en_pc_pulse = pc_now;
    pc_ctrl = ctrl;
    pc_target = tgt;
    imem_ack = 1'b0;
    imem_rdata = 8'($urandom);
    if (pc_now) m_pc = pc_rule(m_pc, ctrl, tgt);
    for (int c = 1; c <= last; c++) begin
      tick;
      exp_req = ok ? (c <= delay + 1) : (c <= TIMEOUT);
      exp_en1 = ok && (c == last);
      exp_err = !ok && (c == last);
      n_checks++;
      if (imem_req !== exp_req) begin
        n_fail++;
        $display("FAIL %s imem_req cycle %0d: got %b want %b", tag, c, imem_req, exp_req);
      end
      n_checks++;
      if (en1 !== exp_en1) begin
        n_fail++;
        $display("FAIL %s en1 cycle %0d: got %b want %b", tag, c, en1, exp_en1);
      end
      n_checks++;
      if (fetch_err !== exp_err) begin
        n_fail++;
        $display("FAIL %s fetch_err cycle %0d: got %b want %b", tag, c, fetch_err, exp_err);
      end
      n_checks++;
      if (imem_addr !== addr_exp) begin
        n_fail++;
        $display("FAIL %s imem_addr cycle %0d: got %h want %h", tag, c, imem_addr, addr_exp);
      end
      n_checks++;
      if (pc !== m_pc) begin
        n_fail++;
        $display("FAIL %s pc cycle %0d: got %h want %h", tag, c, pc, m_pc);
      end
      en_fetch_pulse = spam && (c < last);
      en_pc_pulse = mid_pc && (c == 1);
      pc_ctrl = 2'b01;
      if (mid_pc && c == 1) m_pc = pc_rule(m_pc, 2'b01, 8'h00);
      imem_ack = ok && (c == delay + 1);
      imem_rdata = imem_ack ? rdata : 8'($urandom);
    end
    en_fetch_pulse = 1'b0;
    en_pc_pulse = 1'b0;
    imem_ack = 1'b0;
    if (ok) begin
      m_ir = rdata;
      tick;
      n_checks++;
      if (en1 !== 1'b0 || imem_req !== 1'b0 || fetch_err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle after done: got en1=%b req=%b err=%b want 0 0 0", tag, en1, imem_req, fetch_err);
      end
    end
    n_checks++;
    if ({opcode, rd, rs} !== m_ir) begin
      n_fail++;
      $display("FAIL %s ir fields: got op=%h rd=%0d rs=%0d want %h", tag, opcode, rd, rs, m_ir);
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({imem_req, imem_addr, en1, opcode, rd, rs, pc, fetch_err} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b addr=%h en1=%b ir=%h pc=%h err=%b want all 0",
               imem_req, imem_addr, en1, {opcode, rd, rs}, pc, fetch_err);
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    n_checks++;
    if ({imem_req, en1, pc, fetch_err} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_release: got req=%b en1=%b pc=%h err=%b want 0", imem_req, en1, pc, fetch_err);
    end
    m_pc = 8'h00;
    m_ir = 8'h00;
  endtask

  task automatic test_basic;
    do_fetch(1'b1, 2'b01, 8'h00, 3, 8'h9B, 1'b0, 1'b0, "basic");
    n_checks++;
    if (opcode !== 4'h9 || rd !== 2'd2 || rs !== 2'd3 || pc !== 8'h01) begin
      n_fail++;
      $display("FAIL basic_decode: got op=%h rd=%0d rs=%0d pc=%h want 9 2 3 01", opcode, rd, rs, pc);
    end
  endtask

  task automatic test_pc_update;
    for (int i = 0; i < 5; i++) begin
      en_pc_pulse = 1'b1;
      pc_ctrl = pcu_ctrl[i];
      pc_target = pcu_tgt[i];
      tick;
      en_pc_pulse = 1'b0;
      n_checks++;
      if (pc !== pcu_exp[i]) begin
        n_fail++;
        $display("FAIL pc_update step %0d: got %h want %h", i, pc, pcu_exp[i]);
      end
    end
    m_pc = pcu_exp[4];
    for (int i = 0; i < 12; i++) begin
      en_pc_pulse = 1'($urandom);
      pc_ctrl = 2'($urandom);
      pc_target = 8'($urandom);
      if (en_pc_pulse) m_pc = pc_rule(m_pc, pc_ctrl, pc_target);
      tick;
      n_checks++;
      if (pc !== m_pc) begin
        n_fail++;
        $display("FAIL pc_random step %0d: got %h want %h", i, pc, m_pc);
      end
    end
    en_pc_pulse = 1'b0;
  endtask

  task automatic test_timeout;
    do_fetch(1'b0, 2'b00, 8'h00, TIMEOUT + 3, 8'h5A, 1'b0, 1'b0, "timeout");
    tick;
    n_checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_sticky: got err=%b req=%b want 1 0", fetch_err, imem_req);
    end
    do_fetch(1'b0, 2'b00, 8'h00, 1, 8'hC6, 1'b0, 1'b0, "retry");
  endtask

  task automatic test_spurious;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      imem_rdata = 8'($urandom);
      tick;
      n_checks++;
      if (en1 !== 1'b0 || imem_req !== 1'b0 || {opcode, rd, rs} !== m_ir) begin
        n_fail++;
        $display("FAIL spurious_ack %0d: got en1=%b req=%b ir=%h want 0 0 %h",
                 i, en1, imem_req, {opcode, rd, rs}, m_ir);
      end
    end
    imem_ack = 1'b0;
    do_fetch(1'b0, 2'b00, 8'h00, 4, 8'h3D, 1'b1, 1'b1, "spam");
  endtask

  task automatic test_reset_mid_req;
    en_fetch_pulse = 1'b1;
    tick;
    en_fetch_pulse = 1'b0;
    tick;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({imem_req, imem_addr, en1, opcode, rd, rs, pc, fetch_err} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_mid_req: got req=%b addr=%h en1=%b ir=%h pc=%h err=%b want all 0",
               imem_req, imem_addr, en1, {opcode, rd, rs}, pc, fetch_err);
    end
    tick;
    rst = 1'b0;
    m_pc = 8'h00;
    m_ir = 8'h00;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      imem_rdata = 8'hE7;
      tick;
      n_checks++;
      if (en1 !== 1'b0 || imem_req !== 1'b0 || {opcode, rd, rs} !== 8'h00) begin
        n_fail++;
        $display("FAIL late_ack %0d: got en1=%b req=%b ir=%h want 0 0 00", i, en1, imem_req, {opcode, rd, rs});
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      do_fetch(1'b1, 2'b01, 8'h00, 0, 8'($urandom), 1'b0, 1'b0, "b2b");
    end
    n_checks++;
    if (pc !== 8'h08) begin
      n_fail++;
      $display("FAIL b2b_final_pc: got %h want 08", pc);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      do_fetch(1'($urandom), 2'($urandom), 8'($urandom), int'($urandom_range(0, TIMEOUT + 1)),
               8'($urandom), 1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    en_fetch_pulse = 1'b0;
    en_pc_pulse = 1'b0;
    pc_ctrl = 2'b00;
    pc_target = 8'h00;
    imem_ack = 1'b0;
    imem_rdata = 8'h00;
    m_pc = 8'h00;
    m_ir = 8'h00;
    test_reset;
    test_basic;
    test_pc_update;
    test_timeout;
    test_spurious;
    test_reset_mid_req;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
